// File: rtl/miter_pkg.sv
// miter_pkg: shared FSM state encoding and sample index width for the sequential miter
package miter_pkg;
   localparam int IDX_W = 16;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/miter_chan_cmp.sv
// miter_chan_cmp: masked bitwise compare of one channel, high when any cared bit differs
module miter_chan_cmp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] gold,
   input  logic [WIDTH-1:0] gate,
   input  logic [WIDTH-1:0] care,
   output logic             fail
);
   assign fail = |((gold ^ gate) & care);
endmodule

// File: rtl/miter_seq_cmp.sv
// miter_seq_cmp: windowed gold-vs-gate comparator with sticky per-channel results and first-failure capture
module miter_seq_cmp
   import miter_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 16,
   parameter int STOP_ON_FAIL = 0,
   parameter int CNT_W        = 16,
   localparam int FC_W        = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] gold,
   input  logic [CHANNELS*WIDTH-1:0] gate,
   input  logic [CHANNELS*WIDTH-1:0] care,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      fail,
   output logic [CHANNELS-1:0]       chan_fail,
   output logic [FC_W-1:0]           first_chan,
   output logic [IDX_W-1:0]          first_idx,
   output logic [CNT_W-1:0]          mismatch_cnt
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   state_t              state, state_n;
   logic [CHANNELS-1:0] cf;
   logic [FC_W-1:0]     enc;
   logic [IDX_W-1:0]    smp_cnt;
   logic                smp_fail, last, enter_run;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      miter_chan_cmp #(.WIDTH(WIDTH)) u_cmp (
         .gold (gold[g*WIDTH +: WIDTH]),
         .gate (gate[g*WIDTH +: WIDTH]),
         .care (care[g*WIDTH +: WIDTH]),
         .fail (cf[g])
      );
   end

   assign smp_fail  = |cf;
   assign last      = smp_cnt == LAST;
   assign enter_run = state != RUN && state_n == RUN;
   assign busy      = state == RUN;
   assign pass      = state == DONE && !fail;

   // lowest failing channel wins by scanning downward so the last hit is the smallest index
   always_comb begin
      enc = '0;
      for (int c = CHANNELS - 1; c >= 0; c--)
         if (cf[c]) enc = FC_W'(c);
   end

   // next state: abort beats everything, start is only honoured outside RUN
   always_comb begin
      state_n = state;
      if (abort) state_n = IDLE;
      else if (state != RUN) state_n = start ? RUN : state;
      else if (in_valid && (last || (STOP_ON_FAIL != 0 && smp_fail))) state_n = DONE;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   // result registers: cleared on abort or window open, accumulate on each valid sample in RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst || abort || enter_run) begin
         done         <= 1'b0;
         fail         <= 1'b0;
         chan_fail    <= '0;
         first_chan   <= '0;
         first_idx    <= '0;
         mismatch_cnt <= '0;
         smp_cnt      <= '0;
      end else begin
         done <= state == RUN && state_n == DONE;
         if (state == RUN && in_valid) begin
            smp_cnt <= smp_cnt + 1'b1;
            if (smp_fail) begin
               fail      <= 1'b1;
               chan_fail <= chan_fail | cf;
               if (!fail) begin
                  first_chan <= enc;
                  first_idx  <= smp_cnt;
               end
               if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_miter_seq_cmp.sv
// tb_miter_seq_cmp: directed checks of three miter configurations sharing one stimulus stream
module tb_miter_seq_cmp;
   logic        clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0;
   logic [31:0] gold = 0, gate = 0, care = 0;
   logic        busy0, done0, pass0, fail0, busy1, done1, pass1, fail1, busy2, done2, pass2, fail2;
   logic [3:0]  cf0, cf1, cf2;
   logic [1:0]  fc0, fc1, fc2;
   logic [15:0] fi0, fi1, fi2, mc0, mc1;
   logic [1:0]  mc2;
   int          total = 0, passed = 0;

   always #5 clk = ~clk;

   miter_seq_cmp u0 (.clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
      .gold(gold), .gate(gate), .care(care), .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
      .chan_fail(cf0), .first_chan(fc0), .first_idx(fi0), .mismatch_cnt(mc0));
   miter_seq_cmp #(.STOP_ON_FAIL(1)) u1 (.clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
      .gold(gold), .gate(gate), .care(care), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
      .chan_fail(cf1), .first_chan(fc1), .first_idx(fi1), .mismatch_cnt(mc1));
   miter_seq_cmp #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
      .gold(gold), .gate(gate), .care(care), .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
      .chan_fail(cf2), .first_chan(fc2), .first_idx(fi2), .mismatch_cnt(mc2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic smp(input int i, input logic [31:0] x, input logic [31:0] c);
      in_valid = 1;
      gold = 32'h1234_5678 + i * 32'h0101_0101;
      gate = gold ^ x;
      care = c;
      tick();
      in_valid = 0;
   endtask

   task automatic stop();
      abort = 1;
      tick();
      abort = 0;
   endtask

   initial begin
      tick();
      chk("rst_busy", busy0, 0);
      chk("rst_outs", {done0, pass0, fail0, cf0, fc0, fi0, mc0}, 0);
      rst = 0;
      tick();
      chk("idle_hold", busy0, 0);

      go();
      chk("run_busy", busy0, 1);
      for (int i = 0; i < 15; i++) smp(i, 0, '1);
      chk("clean_pre_done", {done0, busy0}, 2'b01);
      smp(15, 0, '1);
      chk("clean_done", {done0, pass0, busy0}, 3'b110);
      chk("clean_cnt", mc0, 0);
      tick();
      chk("clean_pulse", {done0, pass0}, 2'b01);

      go();
      for (int i = 0; i < 16; i++) smp(i, i == 5 ? 32'h0001_0000 : 0, ~32'h0001_0000);
      chk("masked_pass", {done0, pass0, fail0}, 3'b110);
      chk("masked_pass_sof", {pass1, fail1}, 2'b10);

      go();
      for (int i = 0; i < 5; i++) smp(i, 0, '1);
      smp(5, 32'h0001_0000, '1);
      chk("unmask_fail_lat", fail0, 1);
      chk("unmask_cf", cf0, 4'b0100);
      chk("unmask_fc", fc0, 2);
      chk("unmask_fi", fi0, 5);
      chk("unmask_mc", mc0, 1);
      chk("sof_done_5", {done1, busy1}, 2'b10);
      for (int i = 6; i < 16; i++) smp(i, 0, '1);
      chk("unmask_end", {done0, pass0, fail0, mc0}, {3'b101, 16'd1});
      chk("sof_hold", {pass1, fail1, fi1}, {2'b01, 16'd5});

      go();
      for (int i = 0; i < 3; i++) smp(i, 0, '1);
      smp(3, 32'h0100_0100, '1);
      chk("sof_done", {done1, busy1}, 2'b10);
      chk("sof_fc", fc1, 1);
      chk("sof_cf", cf1, 4'b1010);
      chk("sof_fi", fi1, 3);
      chk("sof_samples", u1.smp_cnt, 4);
      chk("nostop_busy", {busy0, fail0, done0}, 3'b110);
      stop();
      chk("abort_clear", {busy0, done0, pass0, fail0, cf0, mc0, pass1, fail1}, 0);

      go();
      for (int i = 0; i < 6; i++) smp(i, '1, '1);
      chk("sat_cnt", mc2, 3);
      chk("nosat_cnt", mc0, 6);
      stop();

      go();
      for (int i = 0; i < 15; i++) smp(i, i == 2 ? 32'h0000_0080 : 0, '1);
      chk("prio_pre", {busy0, fail0}, 2'b11);
      abort = 1;
      start = 1;
      smp(15, 0, '1);
      abort = 0;
      start = 0;
      chk("prio_idle", {busy0, done0, pass0, fail0, mc0, fi0}, 0);
      tick();
      chk("prio_nodone", {busy0, done0}, 0);

      go();
      for (int i = 0; i < 7; i++) smp(i, i == 1 ? 32'h0000_0001 : 0, '1);
      chk("mid_fail", {busy0, fail0}, 2'b11);
      #2 rst = 1;
      #1;
      chk("async_rst", {busy0, done0, pass0, fail0, cf0, fc0, fi0, mc0}, 0);
      tick();
      rst = 0;
      chk("rst_nodone", {done0, busy0}, 0);
      go();
      for (int i = 0; i < 15; i++) smp(i, 0, '1);
      chk("rerun_busy", {busy0, done0}, 2'b10);
      smp(15, 0, '1);
      chk("rerun_done", {done0, pass0, mc0}, {2'b11, 16'd0});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
